// File: rtl/wsr_pkg.sv
// Shared width helpers and saturating arithmetic for the window shift register.
package wsr_pkg;

   localparam int DEF_SIZE       = 3;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MAX_SHIFT  = 3;

   function automatic int wsr_clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

   // Width of a word count 0..max_shift (CW) and of a fill level 0..size (FW).
   function automatic int count_width(input int max_shift);
      return wsr_clog2(max_shift + 1);
   endfunction

   function automatic int fill_width(input int size);
      return wsr_clog2(size + 1);
   endfunction

   localparam int DEF_CW = count_width(DEF_MAX_SHIFT);
   localparam int DEF_FW = fill_width(DEF_SIZE);

   function automatic int sat_min(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int sat_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/wsr_fill_tracker.sv
// Fill counter and eviction count for the window shift register.
module wsr_fill_tracker
   import wsr_pkg::*;
#(
   parameter int SIZE      = DEF_SIZE,
   parameter int MAX_SHIFT = DEF_MAX_SHIFT,
   parameter int CW        = count_width(MAX_SHIFT),
   parameter int FW        = fill_width(SIZE)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          accept_i,
   input  logic [CW-1:0] k_i,
   output logic [FW-1:0] fill_o,
   output logic [CW-1:0] evict_next_o,
   output logic [CW-1:0] out_count_o,
   output logic          out_valid_o
);

   logic [FW-1:0] fill_q, fill_d;
   logic [CW-1:0] out_count_q, out_count_d;
   logic          out_valid_q, out_valid_d;
   int            evict;

   always_comb begin
      evict        = sat_min(int'(k_i), sat_max(0, int'(fill_q) + int'(k_i) - SIZE));
      evict_next_o = CW'(evict);
      fill_d       = fill_q;
      out_count_d  = out_count_q;
      out_valid_d  = 1'b0;
      if (clear_i) begin
         fill_d      = '0;
         out_count_d = '0;
      end else if (accept_i) begin
         fill_d      = FW'(sat_min(SIZE, int'(fill_q) + int'(k_i)));
         out_count_d = CW'(evict);
         out_valid_d = (evict != 0);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fill_q      <= '0;
         out_count_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fill_q      <= fill_d;
         out_count_q <= out_count_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign fill_o      = fill_q;
   assign out_count_o = out_count_q;
   assign out_valid_o = out_valid_q;

endmodule

// File: rtl/window_shift_register.sv
// Multi-word window shift register with fill tracking and evicted-word output.
// Optional macro WSR_MULTI_SHIFT_EN enables strides of 1..MAX_SHIFT; otherwise every transfer shifts one word.
module window_shift_register
   import wsr_pkg::*;
#(
   parameter int SIZE       = DEF_SIZE,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_SHIFT  = DEF_MAX_SHIFT
) (
   input  logic                              clock_i,
   input  logic                              reset_i,
   input  logic                              clear_i,
   input  logic                              hold_i,
   input  logic                              in_valid_i,
   input  logic [count_width(MAX_SHIFT)-1:0] in_count_i,
   input  logic [DATA_WIDTH*MAX_SHIFT-1:0]   shift_in_i,
   output logic                              in_ready_o,
   output logic [SIZE*DATA_WIDTH-1:0]        data_out_o,
   output logic [fill_width(SIZE)-1:0]       fill_level_o,
   output logic                              window_valid_o,
   output logic [DATA_WIDTH*MAX_SHIFT-1:0]   shift_out_o,
   output logic [count_width(MAX_SHIFT)-1:0] out_count_o,
   output logic                              out_valid_o
);

   localparam int CW = count_width(MAX_SHIFT);
   localparam int FW = fill_width(SIZE);

   logic [DATA_WIDTH-1:0] words [MAX_SHIFT];
   logic [DATA_WIDTH-1:0] data_q [SIZE];
   logic [DATA_WIDTH-1:0] data_d [SIZE];
   logic [DATA_WIDTH-1:0] sout_q [MAX_SHIFT];
   logic [DATA_WIDTH-1:0] sout_d [MAX_SHIFT];
   logic [CW-1:0]         k;
   logic [CW-1:0]         evict_next;
   logic                  accept;

`ifdef WSR_MULTI_SHIFT_EN
   always_comb k = (int'(in_count_i) > MAX_SHIFT) ? CW'(MAX_SHIFT) : in_count_i;

   for (genvar gi = 0; gi < MAX_SHIFT; gi++) begin : g_words
      assign words[gi] = shift_in_i[DATA_WIDTH*gi +: DATA_WIDTH];
   end
`else
   logic unused_inputs;

   assign k             = CW'(1);
   assign unused_inputs = ^{in_count_i, shift_in_i};

   for (genvar gi = 0; gi < MAX_SHIFT; gi++) begin : g_words
      if (gi == 0) begin : g_w0
         assign words[gi] = shift_in_i[DATA_WIDTH-1:0];
      end else begin : g_wz
         assign words[gi] = '0;
      end
   end
`endif

   assign accept = in_valid_i & ~hold_i & ~clear_i & (k != '0);

   wsr_fill_tracker #(
      .SIZE      (SIZE),
      .MAX_SHIFT (MAX_SHIFT),
      .CW        (CW),
      .FW        (FW)
   ) u_fill (
      .clk_i        (clock_i),
      .rst_i        (reset_i),
      .clear_i      (clear_i),
      .accept_i     (accept),
      .k_i          (k),
      .fill_o       (fill_level_o),
      .evict_next_o (evict_next),
      .out_count_o  (out_count_o),
      .out_valid_o  (out_valid_o)
   );

   // Per-slot candidates for each stride; the last word in lands in slot 0.
   for (genvar gi = 0; gi < SIZE; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] cand [MAX_SHIFT];

      for (genvar gs = 1; gs <= MAX_SHIFT; gs++) begin : g_stride
         if (gi >= gs) begin : g_old
            assign cand[gs-1] = data_q[gi-gs];
         end else begin : g_new
            assign cand[gs-1] = words[gs-1-gi];
         end
      end

      always_comb begin
         data_d[gi] = data_q[gi];
         if (clear_i) begin
            data_d[gi] = '0;
         end else if (accept) begin
            for (int s = 0; s < MAX_SHIFT; s++) begin
               if (k == CW'(s + 1)) data_d[gi] = cand[s];
            end
         end
      end

      assign data_out_o[DATA_WIDTH*gi +: DATA_WIDTH] = data_q[gi];
   end

   // Evicted word j is pre-shift slot SIZE-k+j, so word 0 is the newest one leaving.
   for (genvar gj = 0; gj < MAX_SHIFT; gj++) begin : g_evict
      logic [DATA_WIDTH-1:0] ecand [MAX_SHIFT];

      for (genvar gs = 1; gs <= MAX_SHIFT; gs++) begin : g_stride
         if (gj < gs) begin : g_live
            assign ecand[gs-1] = data_q[SIZE-gs+gj];
         end else begin : g_dead
            assign ecand[gs-1] = '0;
         end
      end

      always_comb begin
         sout_d[gj] = sout_q[gj];
         if (clear_i) begin
            sout_d[gj] = '0;
         end else if (accept) begin
            sout_d[gj] = '0;
            if (CW'(gj) < evict_next) begin
               for (int s = 0; s < MAX_SHIFT; s++) begin
                  if (k == CW'(s + 1)) sout_d[gj] = ecand[s];
               end
            end
         end
      end

      assign shift_out_o[DATA_WIDTH*gj +: DATA_WIDTH] = sout_q[gj];
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < SIZE; i++) data_q[i] <= '0;
         for (int j = 0; j < MAX_SHIFT; j++) sout_q[j] <= '0;
      end else begin
         data_q <= data_d;
         sout_q <= sout_d;
      end
   end

   assign in_ready_o     = ~hold_i;
   assign window_valid_o = (fill_level_o == FW'(SIZE));

endmodule

// File: tb/tb_window_shift_register.sv
// Randomised and directed checks of window_shift_register (SIZE=4, DATA_WIDTH=8, MAX_SHIFT=3) against a queue model.
module tb_window_shift_register;

   localparam int SIZE = 4;
   localparam int DW   = 8;
   localparam int MS   = 3;

`ifdef WSR_MULTI_SHIFT_EN
   localparam bit MULTI = 1'b1;
`else
   localparam bit MULTI = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              clear;
   logic              hold;
   logic              in_valid;
   logic [1:0]        in_count;
   logic [DW*MS-1:0]  shift_in;
   logic              in_ready;
   logic [SIZE*DW-1:0] data_out;
   logic [2:0]        fill_level;
   logic              window_valid;
   logic [DW*MS-1:0]  shift_out;
   logic [1:0]        out_count;
   logic              out_valid;

   int n_tests = 0;
   int n_fail  = 0;
   int n_txn   = 0;

   // Reference state: the valid window as a queue (index 0 newest) plus the output registers.
   logic [7:0] mq[$];
   logic [7:0] m_sout [MS];
   int         m_oc;
   bit         m_ov;

   window_shift_register #(
      .SIZE       (SIZE),
      .DATA_WIDTH (DW),
      .MAX_SHIFT  (MS)
   ) dut (
      .clock_i        (clk),
      .reset_i        (rst),
      .clear_i        (clear),
      .hold_i         (hold),
      .in_valid_i     (in_valid),
      .in_count_i     (in_count),
      .shift_in_i     (shift_in),
      .in_ready_o     (in_ready),
      .data_out_o     (data_out),
      .fill_level_o   (fill_level),
      .window_valid_o (window_valid),
      .shift_out_o    (shift_out),
      .out_count_o    (out_count),
      .out_valid_o    (out_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_flush();
      mq.delete();
      for (int j = 0; j < MS; j++) m_sout[j] = 8'h00;
      m_oc = 0;
      m_ov = 1'b0;
   endtask

   task automatic model_edge();
      int         kk;
      logic [7:0] popped[$];
      if (clear) begin
         model_flush();
         return;
      end
      kk = MULTI ? ((int'(in_count) > MS) ? MS : int'(in_count)) : 1;
      if (in_valid && !hold && kk > 0) begin
         for (int j = 0; j < kk; j++) begin
            mq.push_front(shift_in[DW*j +: DW]);
            if (mq.size() > SIZE) popped.push_back(mq.pop_back());
         end
         for (int j = 0; j < MS; j++) m_sout[j] = 8'h00;
         for (int j = 0; j < popped.size(); j++) m_sout[j] = popped[popped.size()-1-j];
         m_oc = popped.size();
         m_ov = (m_oc != 0);
      end else begin
         m_ov = 1'b0;
      end
   endtask

   task automatic check_outputs();
      logic [SIZE*DW-1:0] exp_data;
      logic [DW*MS-1:0]   exp_sout;
      exp_data = '0;
      exp_sout = '0;
      for (int i = 0; i < mq.size(); i++) exp_data[DW*i +: DW] = mq[i];
      for (int j = 0; j < MS; j++) exp_sout[DW*j +: DW] = m_sout[j];
      check_value("data_out", 64'(data_out), 64'(exp_data));
      check_value("fill_level", 64'(fill_level), 64'(mq.size()));
      check_value("window_valid", 64'(window_valid), 64'(mq.size() == SIZE));
      check_value("shift_out", 64'(shift_out), 64'(exp_sout));
      check_value("out_count", 64'(out_count), 64'(m_oc));
      check_value("out_valid", 64'(out_valid), 64'(m_ov));
      check_value("in_ready", 64'(in_ready), 64'(!hold));
   endtask

   task automatic cycle(input bit c, input bit h, input bit v, input int cnt,
                        input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
      clear    = c;
      hold     = h;
      in_valid = v;
      in_count = 2'(cnt);
      shift_in = {w2, w1, w0};
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      n_txn++;
      $display("[TB] txn %0d clr=%0b hold=%0b v=%0b cnt=%0d in=%h -> fill=%0d oc=%0d ov=%0b out=%h",
               n_txn, c, h, v, cnt, shift_in, fill_level, out_count, out_valid, shift_out);
   endtask

   initial begin
      rst      = 1'b1;
      clear    = 1'b0;
      hold     = 1'b0;
      in_valid = 1'b0;
      in_count = 2'd0;
      shift_in = '0;
      model_flush();
      #2;
      check_outputs();
      #10 rst = 1'b0;

      // Fill with unit stride, then one more push evicts the oldest word.
      cycle(0, 0, 1, 1, 8'h11, 8'h00, 8'h00);
      cycle(0, 0, 1, 1, 8'h22, 8'h00, 8'h00);
      cycle(0, 0, 1, 1, 8'h33, 8'h00, 8'h00);
      cycle(0, 0, 1, 1, 8'h44, 8'h00, 8'h00);
      check_value("wv_after_4", 64'(window_valid), 64'd1);
      check_value("slots_44332211", 64'(data_out), 64'h11223344);
      cycle(0, 0, 1, 1, 8'h55, 8'h00, 8'h00);
      check_value("evict_11", 64'(shift_out[7:0]), 64'h11);
      check_value("evict_cnt1", 64'(out_count), 64'd1);

      // Stride-3 on a full window; out_valid must drop on the idle cycle.
      cycle(0, 0, 1, 3, 8'hA0, 8'hA1, 8'hA2);
      if (MULTI) check_value("stride3_slots", 64'(data_out), 64'h55A0A1A2);
      cycle(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      check_value("ov_pulse_end", 64'(out_valid), 64'd0);

      // Partial eviction from fill=2.
      cycle(1, 0, 1, 1, 8'hEE, 8'h00, 8'h00);
      check_value("clear_fill", 64'(fill_level), 64'd0);
      cycle(0, 0, 1, 1, 8'h11, 8'h00, 8'h00);
      cycle(0, 0, 1, 1, 8'h22, 8'h00, 8'h00);
      cycle(0, 0, 1, 3, 8'hB0, 8'hB1, 8'hB2);
      if (MULTI) check_value("partial_out", 64'(shift_out), 64'h000011);

      // Hold, zero count, clear-with-hold priority.
      cycle(0, 1, 1, 2, 8'hC5, 8'hC6, 8'hC7);
      check_value("hold_ready", 64'(in_ready), 64'd0);
      cycle(0, 0, 1, 0, 8'hC8, 8'hC9, 8'hCA);
      cycle(1, 1, 1, 3, 8'hCB, 8'hCC, 8'hCD);
      check_value("clear_data", 64'(data_out), 64'd0);

      // Asynchronous reset between edges after two pushes.
      cycle(0, 0, 1, 1, 8'h61, 8'h00, 8'h00);
      cycle(0, 0, 1, 1, 8'h62, 8'h00, 8'h00);
      #3 rst = 1'b1;
      #1;
      model_flush();
      check_outputs();
      #2 rst = 1'b0;
      cycle(0, 0, 1, 1, 8'h63, 8'h00, 8'h00);
      check_value("post_reset_fill", 64'(fill_level), 64'd1);

      // in_count=3: without multi-shift only word 0 enters.
      cycle(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      cycle(0, 0, 1, 3, 8'hC0, 8'hC1, 8'hC2);
      check_value("slot0_cnt3", 64'(data_out[7:0]), MULTI ? 64'hC2 : 64'hC0);

      for (int n = 0; n < 300; n++) begin
         cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
               8'($urandom), 8'($urandom), 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
